instr_data_mem_responder: RTL

Memory-side responder for the CPU's instruction/data request interface: accepts one request at a time on a valid/ready channel, serves reads and writes from a word-addressed 16-bit array, and returns a response on a valid/ready channel after a programmable wait-state delay. It sits between the CPU fetch/load-store path and on-chip storage. It also replaces array-port program preload with a dedicated init write port.

---
 rtl/cpu_mem_pkg.sv | 14 +
 rtl/mem_array.sv | 33 +++
 rtl/instr_data_mem_responder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared widths and FSM state type for the CPU-side memory responder.
package cpu_mem_pkg;

  localparam int MEM_DATA_W = 16;
  localparam int MEM_ADDR_W = 8;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_WAIT,
    MS_RESP
  } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_W storage: request write port, init write port, one synchronous read port.
module mem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_wdata,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  // Callers only assert the enables for in-range addresses, so the low bits index directly.
  always_ff @(posedge clk) begin
    if (req_we)
      mem[req_addr[IDX_W-1:0]] <= req_wdata;
    if (init_we)
      mem[init_addr[IDX_W-1:0]] <= init_wdata;
    if (rd_en)
      rd_data <= mem[rd_addr[IDX_W-1:0]];
  end

endmodule

// File: rtl/instr_data_mem_responder.sv
// Memory-side responder: one outstanding valid/ready request, programmable wait states, init preload port.
module instr_data_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W      = MEM_DATA_W,
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_wdata
);

  localparam logic [ADDR_W:0]     DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST =
    WAIT_CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  mem_state_t              state, state_next;
  logic [WAIT_CNT_W-1:0]   cnt, cnt_next;

  logic                    lat_we, lat_err;
  logic [ADDR_W-1:0]       lat_addr;

  logic                    accept;
  logic                    req_in_range, init_in_range;
  logic                    cur_we, cur_err;
  logic                    rd_en;
  logic [ADDR_W-1:0]       rd_addr;
  logic [DATA_W-1:0]       rd_data;

  assign req_in_range  = {1'b0, req_addr}  < DEPTH_L;
  assign init_in_range = {1'b0, init_addr} < DEPTH_L;
  assign accept        = req_valid && req_ready;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    req_ready  = 1'b0;
    case (state)
      MS_IDLE: begin
        req_ready = !init_we;
        if (req_valid && !init_we) begin
          state_next = (WAIT_CYCLES == 0) ? MS_RESP : MS_WAIT;
          cnt_next   = '0;
        end
      end
      MS_WAIT: begin
        if (cnt == WAIT_LAST) begin
          state_next = MS_RESP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      MS_RESP: begin
        if (rsp_valid && rsp_ready)
          state_next = MS_IDLE;
      end
      default: state_next = MS_IDLE;
    endcase
  end

  // With zero wait states the read is launched straight from the live request fields.
  always_comb begin
    cur_we  = (state == MS_IDLE) ? req_we        : lat_we;
    cur_err = (state == MS_IDLE) ? !req_in_range : lat_err;
    rd_addr = (state == MS_IDLE) ? req_addr      : lat_addr;
    rd_en   = (state != MS_RESP) && (state_next == MS_RESP) && !cur_we && !cur_err;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MS_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_we   <= 1'b0;
      lat_err  <= 1'b0;
      lat_addr <= '0;
    end else if (accept) begin
      lat_we   <= req_we;
      lat_err  <= !req_in_range;
      lat_addr <= req_addr;
    end
  end

  // Response registers load on the first RESP cycle and hold until consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (state == MS_RESP && !rsp_valid) begin
      rsp_valid <= 1'b1;
      rsp_err   <= lat_err;
      rsp_rdata <= (lat_we || lat_err) ? '0 : rd_data;
    end
  end

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk        (clk),
    .req_we     (accept && req_we && req_in_range),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .init_we    (init_we && init_in_range),
    .init_addr  (init_addr),
    .init_wdata (init_wdata),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

endmodule
